// File: rtl/ccc_lock_supervisor.sv
// Lock supervisor for the FCCC GL0 domain: holds downstream logic in reset until CCC LOCK is stable
// and records lock losses. Optional no-lock watchdog enabled by defining LOCK_WATCHDOG_EN.
module ccc_lock_supervisor #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOCK,
  input  logic             CLR_STATUS,
  output logic             SYS_RESET,
  output logic             READY,
  output logic             LOCK_LOST,
  output logic [CNT_W-1:0] LOSS_COUNT,
  output logic             TIMEOUT
);

  localparam int SW = $clog2(STABLE_CYCLES);

  if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ccc_lock_supervisor: STABLE_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] loss_count_q, loss_count_d;
  logic             lock_s;
  logic [CNT_W-1:0] loss_base_s;
  logic             lost_base_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + 1'b1;
    end
  endfunction

  assign lock_s = sync_q[1];

  // Next-state logic for the synchroniser, lock FSM and status registers.
  always_comb begin
    sync_d     = {sync_q[0], LOCK};
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    case (state_q)
      ST_WAIT: begin
        stab_cnt_d = '0;
        if (lock_s) begin
          state_d = ST_STABLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d    = ST_WAIT;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == SW'(STABLE_CYCLES - 1)) begin
          state_d    = ST_RUN;
          stab_cnt_d = '0;
        end else begin
          state_d    = ST_STABLE;
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d    = ST_WAIT;
        stab_cnt_d = '0;
      end
    endcase

    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);

    // The loss increment is applied on top of a clear in the same cycle, so it wins.
    if (CLR_STATUS) begin
      loss_base_s = '0;
      lost_base_s = 1'b0;
    end else begin
      loss_base_s = loss_count_q;
      lost_base_s = lock_lost_q;
    end
    if (state_q == ST_LOST) begin
      loss_count_d = sat_inc(loss_base_s);
      lock_lost_d  = 1'b1;
    end else begin
      loss_count_d = loss_base_s;
      lock_lost_d  = lost_base_s;
    end
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_WAIT;
      sync_q       <= 2'b00;
      stab_cnt_q   <= '0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      stab_cnt_q   <= stab_cnt_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign SYS_RESET  = sys_reset_q;
  assign READY      = ready_q;
  assign LOCK_LOST  = lock_lost_q;
  assign LOSS_COUNT = loss_count_q;

`ifdef LOCK_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;
  logic          wd_counting_s;
  logic          wd_enter_run_s;
  logic          wd_hit_s;

  // No-lock watchdog: counts WAIT/STABLE cycles, flags once on reaching the limit.
  always_comb begin
    wd_counting_s  = (state_q == ST_WAIT) || (state_q == ST_STABLE);
    wd_enter_run_s = (state_d == ST_RUN) && (state_q != ST_RUN);
    wd_hit_s       = 1'b0;
    if (wd_enter_run_s) begin
      wd_cnt_d = '0;
    end else if (wd_counting_s && (wd_cnt_q != WW'(TIMEOUT_CYCLES - 1))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      wd_hit_s = (wd_cnt_q == WW'(TIMEOUT_CYCLES - 2));
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
    if (wd_hit_s) begin
      timeout_d = 1'b1;
    end else if (CLR_STATUS) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule
